// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding command/response to APB master bridge.
// One command is carried through SETUP and ACCESS to the slave, then the result
// is held in RESP until the consumer takes it. The ACCESS phase can be aborted
// after TIMEOUT_CYCLES wait states; TIMEOUT_CYCLES = 0 waits forever.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // APB master
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  // A disabled timeout still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;

  // Abort only fires once the full wait budget has been spent.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_VAL);

  // Acceptance is a pure state decode so a new command can land the cycle
  // after the response handshake.
  assign cmd_ready = (state == IDLE);

  // Transfer FSM with all APB and response outputs registered.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            // Slave completion: the only cycle where PRDATA/PSLVERR matter.
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? 32'h0 : PRDATA;
            rsp_err   <= PSLVERR;
            state     <= RESP;
          end else if (timeout_hit) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt != {CW{1'b1}}) begin
            // Saturate rather than wrap when the timeout is disabled.
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: drives commands and an APB slave model, compares each
// transfer against a transaction-level reference of the bridge behaviour.
module tb_apb_master_bridge;
  localparam int T = 4;

  logic        PCLK, PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int passed = 0;
  int total  = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          rdy0;
    logic        s_psel, s_pen, s_wr;
    logic [31:0] s_addr, s_wdata;
    int          acc;
    int          unstable;
    logic        r_valid, r_err, r_psel, r_pen;
    logic [31:0] r_rdata;
    int          hold_bad;
    logic        d_ready, d_valid;
    logic [31:0] d_addr;
  } obs_t;

  // Reference: a transfer completes on the first ready cycle unless more than
  // T wait states elapse, in which case it aborts on ACCESS cycle T+1.
  function automatic void model(input bit wr, input int waits, input logic [31:0] prd,
                                input bit slv, output int acc, output bit err,
                                output logic [31:0] rd);
    if (T != 0 && waits > T) begin
      acc = T + 1; err = 1'b1; rd = 32'h0;
    end else begin
      acc = waits + 1; err = slv; rd = wr ? 32'h0 : prd;
    end
  endfunction

  // Runs one transfer from an IDLE negedge and records what the bridge did.
  // Returns at the negedge after the response handshake (IDLE again).
  task automatic drive_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input bit slverr,
                            input int hold, output obs_t o);
    o.rdy0 = cmd_ready;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = $urandom; rsp_ready = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom);
    o.s_psel = PSEL; o.s_pen = PENABLE; o.s_wr = PWRITE; o.s_addr = PADDR; o.s_wdata = PWDATA;
    @(negedge PCLK);
    o.acc = 0; o.unstable = 0;
    while (PSEL === 1'b1 && PENABLE === 1'b1 && o.acc < 64) begin
      o.acc++;
      if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) o.unstable++;
      if (o.acc > waits) begin
        PREADY = 1'b1; PRDATA = rdata; PSLVERR = slverr;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b1;
      end
      @(negedge PCLK);
    end
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b1;
    o.r_valid = rsp_valid; o.r_err = rsp_err; o.r_rdata = rsp_rdata;
    o.r_psel = PSEL; o.r_pen = PENABLE;
    o.hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_addr = $urandom; cmd_write = 1'($urandom);
      @(negedge PCLK);
      if (rsp_valid !== 1'b1 || rsp_rdata !== o.r_rdata || rsp_err !== o.r_err ||
          cmd_ready !== 1'b0 || PSEL !== 1'b0 || PADDR !== addr) o.hold_bad++;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    o.d_ready = cmd_ready; o.d_valid = rsp_valid; o.d_addr = PADDR;
  endtask

  task automatic test_reset();
    PRESET = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; PRDATA = 0; PREADY = 0; PSLVERR = 0;
    #12;
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) $display("FAIL reset_ctrl: got %b exp 000", {PSEL, PENABLE, PWRITE}); else passed++;
    total++; if ({PADDR, PWDATA} !== 64'h0) $display("FAIL reset_bus: got %h exp 0", {PADDR, PWDATA}); else passed++;
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) $display("FAIL reset_rsp: got %h exp 0", {rsp_valid, rsp_err, rsp_rdata}); else passed++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); else passed++;
    @(negedge PCLK); PRESET = 1'b1;
  endtask

  task automatic test_write();
    obs_t o;
    drive_xfer(1'b1, 32'h10, 32'hA5A5A5A5, 32'h12345678, 0, 1'b0, 0, o);
    total++; if (o.rdy0 !== 1'b1) $display("FAIL wr_cmd_ready: got %b exp 1", o.rdy0); else passed++;
    total++; if ({o.s_psel, o.s_pen, o.s_wr} !== 3'b101) $display("FAIL wr_setup_ctrl: got %b exp 101", {o.s_psel, o.s_pen, o.s_wr}); else passed++;
    total++; if (o.s_addr !== 32'h10 || o.s_wdata !== 32'hA5A5A5A5) $display("FAIL wr_setup_bus: got %h/%h exp 10/a5a5a5a5", o.s_addr, o.s_wdata); else passed++;
    total++; if (o.acc !== 1) $display("FAIL wr_access_len: got %0d exp 1", o.acc); else passed++;
    total++; if ({o.r_valid, o.r_err} !== 2'b10) $display("FAIL wr_rsp_flags: got %b exp 10", {o.r_valid, o.r_err}); else passed++;
    total++; if (o.r_rdata !== 32'h0) $display("FAIL wr_rsp_rdata: got %h exp 0", o.r_rdata); else passed++;
    total++; if ({o.r_psel, o.r_pen} !== 2'b00) $display("FAIL wr_resp_apb: got %b exp 00", {o.r_psel, o.r_pen}); else passed++;
    total++; if ({o.d_ready, o.d_valid} !== 2'b10) $display("FAIL wr_done: got %b exp 10", {o.d_ready, o.d_valid}); else passed++;
    total++; if (o.d_addr !== 32'h10) $display("FAIL wr_idle_paddr_kept: got %h exp 10", o.d_addr); else passed++;
  endtask

  task automatic test_read_wait();
    obs_t o;
    drive_xfer(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3, 1'b0, 0, o);
    total++; if (o.acc !== 4) $display("FAIL rd_access_len: got %0d exp 4", o.acc); else passed++;
    total++; if (o.unstable !== 0) $display("FAIL rd_paddr_stable: got %0d exp 0", o.unstable); else passed++;
    total++; if (o.r_rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata: got %h exp deadbeef", o.r_rdata); else passed++;
    total++; if (o.r_err !== 1'b0) $display("FAIL rd_err_ignored_while_waiting: got %b exp 0", o.r_err); else passed++;
  endtask

  task automatic test_error();
    obs_t o;
    drive_xfer(1'b0, 32'h24, 32'h0, 32'h0BADF00D, 2, 1'b1, 0, o);
    total++; if (o.r_err !== 1'b1) $display("FAIL err_pslverr: got %b exp 1", o.r_err); else passed++;
    total++; if (o.r_rdata !== 32'h0BADF00D) $display("FAIL err_rdata: got %h exp 0badf00d", o.r_rdata); else passed++;
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_xfer(1'b0, 32'h80, 32'h0, 32'hFFFF0000, 50, 1'b0, 0, o);
    total++; if (o.acc !== T + 1) $display("FAIL to_access_len: got %0d exp %0d", o.acc, T + 1); else passed++;
    total++; if ({o.r_valid, o.r_err} !== 2'b11) $display("FAIL to_flags: got %b exp 11", {o.r_valid, o.r_err}); else passed++;
    total++; if (o.r_rdata !== 32'h0) $display("FAIL to_rdata: got %h exp 0", o.r_rdata); else passed++;
    total++; if ({o.r_psel, o.r_pen} !== 2'b00) $display("FAIL to_apb_drop: got %b exp 00", {o.r_psel, o.r_pen}); else passed++;
    // Ready arriving exactly on the last allowed cycle must still win.
    drive_xfer(1'b0, 32'h84, 32'h0, 32'h13579BDF, T, 1'b0, 0, o);
    total++; if (o.acc !== T + 1 || o.r_err !== 1'b0 || o.r_rdata !== 32'h13579BDF)
      $display("FAIL to_edge_ready: got acc %0d err %b rd %h exp acc %0d err 0 rd 13579bdf", o.acc, o.r_err, o.r_rdata, T + 1); else passed++;
  endtask

  task automatic test_back_to_back();
    obs_t o, o2;
    drive_xfer(1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 0, 1'b0, 5, o);
    total++; if (o.hold_bad !== 0) $display("FAIL b2b_hold_stable: got %0d bad cycles exp 0", o.hold_bad); else passed++;
    total++; if (o.r_rdata !== 32'hCAFEF00D) $display("FAIL b2b_rdata: got %h exp cafef00d", o.r_rdata); else passed++;
    drive_xfer(1'b1, 32'h104, 32'h55AA55AA, 32'h0, 0, 1'b0, 0, o2);
    total++; if (o2.rdy0 !== 1'b1 || o2.s_psel !== 1'b1 || o2.s_addr !== 32'h104)
      $display("FAIL b2b_next_accept: got rdy %b psel %b addr %h exp 1 1 104", o2.rdy0, o2.s_psel, o2.s_addr); else passed++;
  endtask

  task automatic test_random();
    obs_t o;
    int ea; bit ee; logic [31:0] er;
    int bad;
    for (int n = 0; n < 24; n++) begin
      bit wr; logic [31:0] a, wd, rd; int w; bit se; int h;
      wr = 1'($urandom); a = $urandom; wd = $urandom; rd = $urandom;
      w = $urandom_range(0, 7); se = 1'($urandom); h = $urandom_range(0, 3);
      model(wr, w, rd, se, ea, ee, er);
      drive_xfer(wr, a, wd, rd, w, se, h, o);
      bad = 0;
      if (o.s_addr !== a || o.s_wr !== wr || o.s_wdata !== wd) bad++;
      if (o.acc !== ea || o.unstable !== 0 || o.hold_bad !== 0) bad++;
      if (o.r_valid !== 1'b1 || o.r_err !== ee || o.r_rdata !== er) bad++;
      if (o.d_ready !== 1'b1 || o.d_valid !== 1'b0) bad++;
      total++;
      if (bad != 0)
        $display("FAIL rand_xfer%0d: got acc %0d err %b rd %h addr %h exp acc %0d err %b rd %h addr %h", n, o.acc, o.r_err, o.r_rdata, o.s_addr, ea, ee, er, a);
      else passed++;
    end
  endtask

  task automatic test_reset_access();
    int bad;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; PREADY = 1'b0;
    @(negedge PCLK); cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    #2 PRESET = 1'b0;
    #1;
    total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) $display("FAIL rst_access_async: got %b exp 000", {PSEL, PENABLE, rsp_valid}); else passed++;
    total++; if (PADDR !== 32'h0 || cmd_ready !== 1'b1) $display("FAIL rst_access_state: got paddr %h rdy %b exp 0 1", PADDR, cmd_ready); else passed++;
    @(negedge PCLK);
    PRESET = 1'b1; PREADY = 1'b1; PRDATA = 32'h77777777; PSLVERR = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) bad++;
    end
    PREADY = 1'b0;
    total++; if (bad !== 0) $display("FAIL rst_no_response: got %0d bad cycles exp 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute bound so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
